// File: rtl/seven_seg_sched.sv
// seven_seg_sched: time-shares the 16-bit seven-segment value between four
// requesters (CPU MMIO, PC trace, switch echo, error codes) using round-robin
// arbitration with a minimum dwell so each value stays readable.
// Optional build macro SEVEN_SEG_SCHED_PREEMPT_EN: a rising i_req[3] (error
// codes) takes the display immediately from any other owner.
module seven_seg_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ*16-1:0]   i_data,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [1:0]              o_owner,
  output logic [15:0]             o_data,
  output logic                    o_busy
);

  typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t                   state;
  logic [1:0]               ptr;
  logic [CNT_W-1:0]         cnt;
  logic [1:0]               rst_sync;
  logic                     rst_int;
  logic [NUM_REQ-1:0][15:0] req_data;
  logic [1:0]               arb_start;
  logic [NUM_REQ-1:0]       arb_mask;
  logic                     arb_hit;
  logic [1:0]               arb_idx;
  logic [1:0]               cand;
  logic                     preempt;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Split the flat data bus into one 16-bit value per requester
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign req_data[k] = i_data[16*k +: 16];
  end

  // Reset asserts immediately, releases two clocks after i_rst falls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

`ifdef SEVEN_SEG_SCHED_PREEMPT_EN
  logic req3_q;

  // Remember last i_req[3] so only its rising edge preempts
  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) req3_q <= 1'b0;
    else         req3_q <= i_req[3];
  end
  assign preempt = i_req[3] && !req3_q && o_busy && (o_owner != 2'd3);
`else
  assign preempt = 1'b0;
`endif

  // Round-robin pick: from pointer in IDLE, from owner+1 (owner masked) in HOLD
  always_comb begin
    arb_start = ptr;
    arb_mask  = i_req;
    if (state == HOLD) begin
      arb_start         = o_owner + 2'd1;
      arb_mask[o_owner] = 1'b0;
    end
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    // Walk downward so the closest index to arb_start wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = arb_start + 2'(i);
      if (arb_mask[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Ownership FSM with registered grant/owner/busy/data outputs
  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      o_grant <= '0;
      o_owner <= '0;
      o_data  <= '0;
      o_busy  <= 1'b0;
    end else begin
      // Follow the owner's value only while it is still requesting
      if (state != IDLE && i_req[o_owner]) o_data <= req_data[o_owner];

      if (preempt) begin
        // Error codes jump the queue; pointer untouched so rotation resumes
        o_grant <= onehot(2'd3);
        o_owner <= 2'd3;
        o_busy  <= 1'b1;
        cnt     <= '0;
        state   <= DWELL;
      end else begin
        case (state)
          IDLE: begin
            if (arb_hit) begin
              o_grant <= onehot(arb_idx);
              o_owner <= arb_idx;
              o_busy  <= 1'b1;
              ptr     <= arb_idx + 2'd1;
              cnt     <= '0;
              state   <= DWELL;
            end
          end
          DWELL: begin
            // Counter parks at the last value; it never wraps
            if (cnt == DWELL_LAST) state <= HOLD;
            else                   cnt   <= cnt + CNT_W'(1);
          end
          HOLD: begin
            if (arb_hit) begin
              o_grant <= onehot(arb_idx);
              o_owner <= arb_idx;
              ptr     <= arb_idx + 2'd1;
              cnt     <= '0;
              state   <= DWELL;
            end else if (!i_req[o_owner]) begin
              o_grant <= '0;
              o_busy  <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_sched.sv
// tb_seven_seg_sched: directed vectors plus hand sequences for dwell,
// hold, release, pointer, async reset and the preempt option.
module tb_seven_seg_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_req = '0;
  logic [63:0] i_data = '0;
  logic [3:0]  o_grant;
  logic [1:0]  o_owner;
  logic [15:0] o_data;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  seven_seg_sched #(.NUM_REQ(4), .DWELL_CYCLES(8), .CNT_W(4)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .i_data (i_data),
    .o_grant(o_grant),
    .o_owner(o_owner),
    .o_data (o_data),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] dat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_req = '0;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int n;
    int bad;

    vecs[0]  = '{4'b0000, 64'h0,                                   4'b0000, 2'd0, 1'b0, 16'h0000};
    vecs[1]  = '{4'b0010, {16'h0, 16'h0, 16'hBEEF, 16'h0},         4'b0010, 2'd1, 1'b1, 16'h0000};
    vecs[2]  = '{4'b0010, {16'h0, 16'h0, 16'hBEEF, 16'h0},         4'b0010, 2'd1, 1'b1, 16'hBEEF};
    vecs[3]  = '{4'b0010, {16'h0, 16'h0, 16'h1234, 16'h0},         4'b0010, 2'd1, 1'b1, 16'h1234};
    for (int i = 4; i <= 9; i++)
      vecs[i] = '{4'b0000, {16'h0, 16'h0, 16'h5555, 16'h0},        4'b0010, 2'd1, 1'b1, 16'h1234};
    vecs[10] = '{4'b0000, {16'h0, 16'h0, 16'h5555, 16'h0},         4'b0000, 2'd1, 1'b0, 16'h1234};
    vecs[11] = '{4'b0101, {16'h0, 16'hCCCC, 16'h5555, 16'hAAAA},   4'b0100, 2'd2, 1'b1, 16'h1234};

    do_reset();

    // Table: reset state, grant latency, data latency, drop during dwell, release, pointer
    for (int i = 0; i < 12; i++) begin
      i_req  = vecs[i].req;
      i_data = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_grant", i), 64'(o_grant), 64'(vecs[i].grant));
      chk($sformatf("vec%0d_owner", i), 64'(o_owner), 64'(vecs[i].owner));
      chk($sformatf("vec%0d_busy",  i), 64'(o_busy),  64'(vecs[i].busy));
      chk($sformatf("vec%0d_data",  i), 64'(o_data),  64'(vecs[i].dat));
    end

    // Async reset in the middle of a dwell: outputs clear without a clock edge
    i_req = '0;
    #3 i_rst = 1'b1;
    #1;
    chk("async_rst_grant", 64'(o_grant), 64'h0);
    chk("async_rst_owner", 64'(o_owner), 64'h0);
    chk("async_rst_data",  64'(o_data),  64'h0);
    chk("async_rst_busy",  64'(o_busy),  64'h0);
    do_reset();
    i_req  = 4'b1000;
    i_data = {16'hE0E0, 48'h0};
    tick();
    chk("post_rst_grant", 64'(o_grant), 64'h8);
    chk("post_rst_owner", 64'(o_owner), 64'h3);
    tick();
    chk("post_rst_data",  64'(o_data),  64'hE0E0);

    // Two requesters: 8 dwell + 1 hold cycles, then direct switch, pointer -> 3
    do_reset();
    i_req  = 4'b0101;
    i_data = {16'h0, 16'hCCCC, 16'h0, 16'hAAAA};
    tick();
    chk("rr_first_grant", 64'(o_grant), 64'h1);
    n = 0;
    while (o_grant == 4'b0001 && n < 40) begin
      n++;
      tick();
    end
    chk("rr_dwell_len", 64'(n), 64'd9);
    chk("rr_no_gap", 64'(o_grant), 64'h4);
    i_req = '0;
    for (int k = 0; k < 40 && o_busy; k++) tick();
    chk("rr_release_busy", 64'(o_busy), 64'h0);
    i_req = 4'b1001;
    tick();
    chk("ptr_wrap_grant", 64'(o_grant), 64'h8);

    // Uncontested owner keeps the display indefinitely, then releases
    do_reset();
    i_req  = 4'b0001;
    i_data = {48'h0, 16'h1111};
    tick();
    bad = 0;
    repeat (100) begin
      tick();
      if (o_grant != 4'b0001) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    chk("hold_data", 64'(o_data), 64'h1111);
    i_req  = '0;
    i_data = {48'h0, 16'h2222};
    tick();
    chk("hold_rel_grant", 64'(o_grant), 64'h0);
    chk("hold_rel_busy",  64'(o_busy),  64'h0);
    chk("hold_rel_data",  64'(o_data),  64'h1111);
    chk("hold_rel_owner", 64'(o_owner), 64'h0);

    // Requester 3 rises while owner 0 is at dwell count 3
    do_reset();
    i_req  = 4'b0001;
    i_data = {16'hEEEE, 32'h0, 16'h0101};
    repeat (4) tick();
    i_req = 4'b1001;
    tick();
    n = 0;
    while (o_grant == 4'b0001 && n < 20) begin
      n++;
      tick();
    end
`ifdef SEVEN_SEG_SCHED_PREEMPT_EN
    chk("req3_wait", 64'(n), 64'd0);
`else
    chk("req3_wait", 64'(n), 64'd5);
`endif
    chk("req3_grant", 64'(o_grant), 64'h8);
    n = 0;
    while (o_grant == 4'b1000 && n < 20) begin
      n++;
      tick();
    end
    chk("req3_dwell_len", 64'(n), 64'd9);
    chk("req3_back_to_0", 64'(o_grant), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_sched.md
Name: seven_seg_sched

Overview:
- Time-shares the single 16-bit seven-segment display value between NUM_REQ requesters: CPU MMIO, debug/PC trace, switch echo and error codes.
- Round-robin arbitration with a minimum dwell time, so each owner's value stays visible long enough to read.
- o_data feeds the 16-bit data input of the display multiplex controller.
- Sits in the io subsystem between the requesters and the display controller.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4; o_owner is 2 bits.
- DWELL_CYCLES, 50000000, minimum cycles an owner keeps the display after grant (1 s at 50 MHz); must be >= 1.
- CNT_W, 26, width of the dwell counter; must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous reset, active high.
- i_req  in  4  per-requester request level; high = wants the display.
- i_data  in  64  requester values; requester k uses bits [16k+15:16k].
- o_grant  out  4  one-hot grant; all zero when idle.
- o_owner  out  2  index of the current or most recent owner.
- o_data  out  16  value for the display controller.
- o_busy  out  1  high while some requester owns the display.

Behaviour:
- Reset (async assert; release synchronised internally with a 2-flop chain):
  - o_grant=0, o_owner=0, o_data=16'h0000, o_busy=0.
  - Round-robin pointer=0, dwell counter=0, state=IDLE.
- States: IDLE, DWELL, HOLD.
- IDLE:
  - No grant.
  - If any i_req bit is high, grant the first requesting index at or after the pointer, searching upward with wrap at 3.
  - Next cycle: o_grant one-hot, o_owner=index, o_busy=1, dwell counter=0, state=DWELL.
  - Grant latency from req to grant is 1 cycle.
- DWELL:
  - Counter increments every cycle.
  - When counter == DWELL_CYCLES-1, go to HOLD next cycle.
  - Owner deasserting req in DWELL does not release; the display keeps the last captured value until dwell ends.
- HOLD:
  - If any other requester is pending: switch grant directly to the next one round-robin after the owner, same cycle rules as from IDLE, restart counter, state=DWELL. There is no idle gap.
  - Else if owner req is still high: remain in HOLD. Ownership is indefinite while uncontested.
  - Else (owner released, none pending): o_grant=0, o_busy=0, state=IDLE, o_data retains the last value, o_owner retains the last owner.
- Pointer update: on every grant, pointer = granted index + 1 (mod 4).
- o_data:
  - Registered.
  - Each cycle the owner's req is high in DWELL/HOLD, o_data <= owner's i_data slice, one cycle latency.
  - When the owner's req is low, o_data holds.
- Simultaneous events:
  - Multiple reqs in IDLE are resolved by the pointer only.
  - A req rising on the same cycle as the HOLD decision is considered.
  - An owner re-requesting in the same cycle another requester wins loses; it waits for its turn.
- Counter saturates at DWELL_CYCLES-1 in HOLD and does not wrap.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro SEVEN_SEG_SCHED_PREEMPT_EN.
- Defined:
  - Requester 3 (error codes) is a high-priority requester.
  - When i_req[3] rises while another index owns the display, in any state, the grant moves to 3 on the next cycle, bypassing dwell.
  - Counter restarts; pointer is not updated by a preemptive grant.
- Undefined: requester 3 is an ordinary round-robin participant.

Test Plan:
- Reset, then req=4'b0010 with data1=16'hBEEF -> cycle+1: grant=0010, owner=1, busy=1; cycle+2: o_data=BEEF.
- req=4'b0101 from IDLE with pointer=0, DWELL_CYCLES=8 -> grant=0001 for exactly 8 DWELL cycles plus 1 HOLD cycle, then grant=0100 with no idle cycle; pointer=3.
- Single req held for 100 cycles, DWELL_CYCLES=8 -> grant stays constant (HOLD); drop req -> next cycle grant=0, busy=0, o_data retains last value.
- Owner drops req at dwell cycle 2 while data changes -> o_data frozen at value captured before the drop; release only after dwell expires.
- Assert i_rst mid-DWELL asynchronously -> outputs zero within the same cycle, without waiting for a clock edge; after deassert, req=1000 -> grant=1000.
- PREEMPT_EN: owner 0 in DWELL at counter 3, raise i_req[3] -> next cycle grant=1000, counter=0; without the macro, grant=1000 only after dwell plus HOLD.
